// File: rtl/vc_arbitro.sv
// Weighted round-robin scheduler moving words from two VC FIFOs into two destination FIFOs.
// Optional grant statistics are built only when ARB_STATS_EN is defined.
//
// state | meaning
// OFF   | idle, control FSM not active; no grants
// RUN   | scheduling allowed while active_in stays high
// HALT  | sticky error stop, left only through reset
module vc_arbitro #(
   parameter int DATA_WIDTH = 6,
   parameter int DEST_BIT   = 4,
   parameter int WEIGHT_VC0 = 3
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  active_in,
   input  logic                  error_in,
   input  logic                  vc0_empty,
   input  logic                  vc1_empty,
   input  logic [DATA_WIDTH-1:0] vc0_data,
   input  logic [DATA_WIDTH-1:0] vc1_data,
   input  logic                  d0_almost_full,
   input  logic                  d1_almost_full,
   output logic                  vc0_pop,
   output logic                  vc1_pop,
   output logic                  d0_push,
   output logic                  d1_push,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  halted,
   output logic [15:0]           gnt_cnt_vc0,
   output logic [15:0]           gnt_cnt_vc1
);

   localparam logic [1:0] WEIGHT = 2'(WEIGHT_VC0);

   typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_HALT} state_t;

   state_t                state, state_nxt;
   logic [1:0]            cnt, cnt_nxt;
   logic                  sched_ok, elig0, elig1, gnt0, gnt1;
   logic [DATA_WIDTH-1:0] gnt_word;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state <= ST_OFF;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      gnt_word  = vc0_data;
      sched_ok  = (state == ST_RUN) && active_in && !error_in;
      elig0     = sched_ok && !vc0_empty &&
                  !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
      elig1     = sched_ok && !vc1_empty &&
                  !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);

      // cnt only advances while VC1 is actually being held off
      if (elig0 && elig1) begin
         if (cnt == WEIGHT) begin
            gnt1    = 1'b1;
            cnt_nxt = 2'd0;
         end else begin
            gnt0    = 1'b1;
            cnt_nxt = cnt + 2'd1;
         end
      end else if (elig0) begin
         gnt0 = 1'b1;
      end else if (elig1) begin
         gnt1    = 1'b1;
         cnt_nxt = 2'd0;
      end
      if (gnt1) gnt_word = vc1_data;

      case (state)
         ST_OFF:  if (active_in)  state_nxt = ST_RUN;
         ST_RUN:  if (!active_in) state_nxt = ST_OFF;
         default: state_nxt = ST_HALT;
      endcase
      if (error_in) state_nxt = ST_HALT;
   end

   assign vc0_pop = gnt0;
   assign vc1_pop = gnt1;
   assign halted  = (state == ST_HALT);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         d0_push  <= 1'b0;
         d1_push  <= 1'b0;
         data_out <= '0;
      end else if (gnt0 || gnt1) begin
         d0_push  <= !gnt_word[DEST_BIT];
         d1_push  <= gnt_word[DEST_BIT];
         data_out <= gnt_word;
      end else begin
         d0_push  <= 1'b0;
         d1_push  <= 1'b0;
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] stat0, stat1;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         stat0 <= 16'd0;
         stat1 <= 16'd0;
      end else if (state != ST_HALT) begin
         if (gnt0 && stat0 != 16'hFFFF) stat0 <= stat0 + 16'd1;
         if (gnt1 && stat1 != 16'hFFFF) stat1 <= stat1 + 16'd1;
      end
   end

   assign gnt_cnt_vc0 = stat0;
   assign gnt_cnt_vc1 = stat1;
`else
   assign gnt_cnt_vc0 = 16'd0;
   assign gnt_cnt_vc1 = 16'd0;
`endif

endmodule
